alu_rs_sched: RTL and testbench



---
 rtl/ooo_pkg.sv | 56 +++++
 rtl/alu_rs_sched_rs_entry.sv | 37 +++
 rtl/alu_rs_sched.sv | 182 ++++++++++++++++++
 tb/tb_alu_rs_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order integer back end.
package ooo_pkg;

   localparam int TAGW = 4;
   localparam int DW   = 32;

   // ALU funct / opcode encodings (MIPS-style R-type + immediates)
   localparam logic [5:0] FUNCT_ADD   = 6'd32;
   localparam logic [5:0] FUNCT_SUB   = 6'd34;
   localparam logic [5:0] FUNCT_AND   = 6'd36;
   localparam logic [5:0] FUNCT_OR    = 6'd37;
   localparam logic [5:0] FUNCT_SLT   = 6'd42;
   localparam logic [5:0] OPCODE_RTYPE = 6'd0;
   localparam logic [5:0] OPCODE_ADDI  = 6'd8;

   typedef enum logic [2:0] {
      ITYPE_EMPTY  = 3'd0,
      ITYPE_ALU    = 3'd1,
      ITYPE_LOAD   = 3'd2,
      ITYPE_STORE  = 3'd3,
      ITYPE_BRANCH = 3'd4
   } itype_e;

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
      logic [5:0]      funct;
      logic [5:0]      opcode;
      logic [DW-1:0]   v1;
      logic [TAGW-1:0] q1;
      logic            bsy1;
      logic [DW-1:0]   v2;
      logic [TAGW-1:0] q2;
      logic            bsy2;
   } rs_entry_t;

   // Apply a CDB broadcast to an entry: any pending operand whose producer
   // tag matches captures the broadcast value and stops waiting.
   function automatic rs_entry_t rs_snoop(input rs_entry_t e,
                                          input logic cv,
                                          input logic [TAGW-1:0] ct,
                                          input logic [DW-1:0] cval);
      rs_entry_t r;
      r = e;
      if (e.valid && cv && e.bsy1 && (e.q1 == ct)) begin
         r.v1   = cval;
         r.bsy1 = 1'b0;
      end
      if (e.valid && cv && e.bsy2 && (e.q2 == ct)) begin
         r.v2   = cval;
         r.bsy2 = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_rs_sched_rs_entry.sv
// One reservation-station slot: storage, CDB snoop and ready flag.
// The woken view is what the slot would hold after this edge's broadcast;
// the top uses it as the source for both hold and shift-down moves.
module rs_entry
   import ooo_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            cdb_valid_i,
   input  logic [TAGW-1:0] cdb_tag_i,
   input  logic [DW-1:0]   cdb_value_i,
   input  rs_entry_t       ent_d_i,
   output rs_entry_t       ent_q_o,
   output rs_entry_t       ent_woken_o,
   output logic            ready_o
);

   rs_entry_t ent_q;

   // Slot register; flush empties it regardless of the incoming value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_q <= '0;
      end else if (flush_i) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d_i;
      end
   end

   assign ent_q_o     = ent_q;
   assign ent_woken_o = rs_snoop(ent_q, cdb_valid_i, cdb_tag_i, cdb_value_i);
   // Ready uses registered state only, so a wakeup is selectable next cycle
   assign ready_o     = ent_q.valid && !ent_q.bsy1 && !ent_q.bsy2;

endmodule

// File: rtl/alu_rs_sched.sv
// Reservation station + issue scheduler for the shared integer ALU.
// Slots form a compacting queue (slot 0 oldest); the oldest ready op is
// moved to an issue register that drives the ALU, and the ALU result is
// registered with its ROB tag for writeback.
module alu_rs_sched
   import ooo_pkg::*;
#(
   parameter int NENT = 4
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            disp_valid,
   output logic            disp_ready,
   input  logic [TAGW-1:0] disp_tag,
   input  logic [5:0]      disp_funct,
   input  logic [5:0]      disp_opcode,
   input  logic [DW-1:0]   disp_v1,
   input  logic [TAGW-1:0] disp_q1,
   input  logic            disp_bsy1,
   input  logic [DW-1:0]   disp_v2,
   input  logic [TAGW-1:0] disp_q2,
   input  logic            disp_bsy2,
   input  logic            cdb_valid,
   input  logic [TAGW-1:0] cdb_tag,
   input  logic [DW-1:0]   cdb_value,
   input  logic            flush,
   output logic [DW-1:0]   alu_src1,
   output logic [DW-1:0]   alu_src2,
   output logic [5:0]      alu_funct,
   output logic [5:0]      alu_opcode,
   input  logic [DW-1:0]   alu_result,
   output logic            wb_valid,
   output logic [TAGW-1:0] wb_tag,
   output logic [DW-1:0]   wb_value
);

   localparam int OCCW = $clog2(NENT + 1);

   rs_entry_t        ent_q     [NENT];
   rs_entry_t        ent_woken [NENT];
   rs_entry_t        ent_d     [NENT];
   logic [NENT-1:0]  ready;
   logic [NENT-1:0]  sel_oh;
   logic [NENT-1:0]  shift_mask;
   logic             issue_fire;
   rs_entry_t        sel_ent;
   rs_entry_t        disp_raw;
   rs_entry_t        disp_ent;
   logic             disp_fire;
   logic [OCCW-1:0]  occ_q, occ_d;
   logic [OCCW-1:0]  free_idx;

   logic             iss_valid_q;
   logic [TAGW-1:0]  iss_tag_q;
   logic [DW-1:0]    alu_src1_q, alu_src2_q;
   logic [5:0]       alu_funct_q, alu_opcode_q;
   logic             wb_valid_q;
   logic [TAGW-1:0]  wb_tag_q;
   logic [DW-1:0]    wb_value_q;

   // Lowest-index ready slot wins; every slot at or above it shifts down
   always_comb begin
      sel_oh     = '0;
      shift_mask = '0;
      sel_ent    = '0;
      issue_fire = 1'b0;
      for (int i = 0; i < NENT; i++) begin
         if (!issue_fire && ready[i]) begin
            sel_oh[i]  = 1'b1;
            sel_ent    = ent_q[i];
            issue_fire = 1'b1;
         end
         shift_mask[i] = issue_fire;
      end
   end

   // Dispatched op as stored, including bypass of a same-cycle broadcast
   always_comb begin
      disp_raw        = '0;
      disp_raw.valid  = 1'b1;
      disp_raw.tag    = disp_tag;
      disp_raw.funct  = disp_funct;
      disp_raw.opcode = disp_opcode;
      disp_raw.v1     = disp_v1;
      disp_raw.q1     = disp_q1;
      disp_raw.bsy1   = disp_bsy1;
      disp_raw.v2     = disp_v2;
      disp_raw.q2     = disp_q2;
      disp_raw.bsy2   = disp_bsy2;
   end

   assign disp_ent   = rs_snoop(disp_raw, cdb_valid, cdb_tag, cdb_value);
   assign disp_ready = (occ_q < OCCW'(NENT));
   assign disp_fire  = disp_valid && disp_ready;
   // Valid slots are contiguous from 0, so the first free slot after this
   // edge's compaction is the post-issue occupancy.
   assign free_idx   = occ_q - OCCW'(issue_fire);

   for (genvar gi = 0; gi < NENT; gi++) begin : g_slot
      rs_entry_t slot_above;
      if (gi == NENT - 1) begin : g_top
         assign slot_above = '0;
      end else begin : g_mid
         assign slot_above = ent_woken[gi + 1];
      end

      assign ent_d[gi] = (disp_fire && (free_idx == OCCW'(gi))) ? disp_ent :
                         shift_mask[gi]                         ? slot_above :
                                                                  ent_woken[gi];

      rs_entry u_entry (
         .clk         (clk),
         .rst         (rst),
         .flush_i     (flush),
         .cdb_valid_i (cdb_valid),
         .cdb_tag_i   (cdb_tag),
         .cdb_value_i (cdb_value),
         .ent_d_i     (ent_d[gi]),
         .ent_q_o     (ent_q[gi]),
         .ent_woken_o (ent_woken[gi]),
         .ready_o     (ready[gi])
      );
   end

   assign occ_d = flush ? '0 : (occ_q - OCCW'(issue_fire) + OCCW'(disp_fire));

   // Occupancy counter; issue and dispatch in one cycle cancel out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   // Issue register: loads the selected op; ALU inputs hold when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss_valid_q  <= 1'b0;
         iss_tag_q    <= '0;
         alu_src1_q   <= '0;
         alu_src2_q   <= '0;
         alu_funct_q  <= '0;
         alu_opcode_q <= '0;
      end else if (flush) begin
         iss_valid_q  <= 1'b0;
      end else begin
         iss_valid_q <= issue_fire;
         if (issue_fire) begin
            iss_tag_q    <= sel_ent.tag;
            alu_src1_q   <= sel_ent.v1;
            alu_src2_q   <= sel_ent.v2;
            alu_funct_q  <= sel_ent.funct;
            alu_opcode_q <= sel_ent.opcode;
         end
      end
   end

   // Writeback register: captures the combinational ALU result one cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid_q <= 1'b0;
         wb_tag_q   <= '0;
         wb_value_q <= '0;
      end else begin
         wb_valid_q <= iss_valid_q && !flush;
         if (iss_valid_q && !flush) begin
            wb_tag_q   <= iss_tag_q;
            wb_value_q <= alu_result;
         end
      end
   end

   assign alu_src1   = alu_src1_q;
   assign alu_src2   = alu_src2_q;
   assign alu_funct  = alu_funct_q;
   assign alu_opcode = alu_opcode_q;
   assign wb_valid   = wb_valid_q;
   assign wb_tag     = wb_tag_q;
   assign wb_value   = wb_value_q;

endmodule

// File: tb/tb_alu_rs_sched.sv
// Directed bench for alu_rs_sched with hand-computed expectations.
module tb_alu_rs_sched;

   logic        clk;
   logic        rst;
   logic        disp_valid;
   logic        disp_ready;
   logic [3:0]  disp_tag;
   logic [5:0]  disp_funct;
   logic [5:0]  disp_opcode;
   logic [31:0] disp_v1;
   logic [3:0]  disp_q1;
   logic        disp_bsy1;
   logic [31:0] disp_v2;
   logic [3:0]  disp_q2;
   logic        disp_bsy2;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        flush;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic [5:0]  alu_funct;
   logic [5:0]  alu_opcode;
   logic [31:0] alu_result;
   logic        wb_valid;
   logic [3:0]  wb_tag;
   logic [31:0] wb_value;

   int tests_run;
   int tests_failed;

   alu_rs_sched #(.NENT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .disp_valid  (disp_valid),
      .disp_ready  (disp_ready),
      .disp_tag    (disp_tag),
      .disp_funct  (disp_funct),
      .disp_opcode (disp_opcode),
      .disp_v1     (disp_v1),
      .disp_q1     (disp_q1),
      .disp_bsy1   (disp_bsy1),
      .disp_v2     (disp_v2),
      .disp_q2     (disp_q2),
      .disp_bsy2   (disp_bsy2),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_value   (cdb_value),
      .flush       (flush),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_funct   (alu_funct),
      .alu_opcode  (alu_opcode),
      .alu_result  (alu_result),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .wb_value    (wb_value)
   );

   // Minimal ALU: add (32), sub (34), anything else xor
   assign alu_result = (alu_funct == 6'd32) ? alu_src1 + alu_src2 :
                       (alu_funct == 6'd34) ? alu_src1 - alu_src2 :
                                              alu_src1 ^ alu_src2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [3:0] tag, input logic [5:0] funct,
                       input logic [31:0] v1, input logic [3:0] q1, input logic b1,
                       input logic [31:0] v2, input logic [3:0] q2, input logic b2);
      disp_valid  = 1'b1;
      disp_tag    = tag;
      disp_funct  = funct;
      disp_opcode = 6'd0;
      disp_v1     = v1;
      disp_q1     = q1;
      disp_bsy1   = b1;
      disp_v2     = v2;
      disp_q2     = q2;
      disp_bsy2   = b2;
   endtask

   task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] val);
      cdb_valid = v;
      cdb_tag   = tag;
      cdb_value = val;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      flush        = 1'b0;
      disp_valid   = 1'b0;
      disp_tag     = '0;
      disp_funct   = '0;
      disp_opcode  = '0;
      disp_v1      = '0;
      disp_q1      = '0;
      disp_bsy1    = 1'b0;
      disp_v2      = '0;
      disp_q2      = '0;
      disp_bsy2    = 1'b0;
      cdb(1'b0, 4'd0, 32'd0);

      // Reset state
      repeat (2) step();
      check("reset disp_ready", {31'd0, disp_ready}, 32'd1);
      check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
      check("reset alu_src1", alu_src1, 32'd0);
      check("reset wb_tag", {28'd0, wb_tag}, 32'd0);
      rst = 1'b1;
      step();

      // 1: ready add, 5 + 7, tag 3
      disp(4'd3, 6'd32, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0);
      step();
      disp_valid = 1'b0;
      check("t1 no issue yet", alu_src1, 32'd0);
      step();
      check("t1 alu_src1", alu_src1, 32'd5);
      check("t1 alu_src2", alu_src2, 32'd7);
      check("t1 alu_funct", {26'd0, alu_funct}, 32'd32);
      check("t1 wb_valid early", {31'd0, wb_valid}, 32'd0);
      step();
      check("t1 wb_valid", {31'd0, wb_valid}, 32'd1);
      check("t1 wb_tag", {28'd0, wb_tag}, 32'd3);
      check("t1 wb_value", wb_value, 32'd12);
      step();
      check("t1 wb one cycle", {31'd0, wb_valid}, 32'd0);

      // 2: src1 waits on tag 9, woken by CDB value 100
      disp(4'd2, 6'd32, 32'd0, 4'd9, 1'b1, 32'd3, 4'd0, 1'b0);
      step();
      disp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2 waiting no wb", {31'd0, wb_valid}, 32'd0);
      end
      check("t2 waiting alu hold", alu_src1, 32'd5);
      cdb(1'b1, 4'd9, 32'd100);
      step();
      cdb(1'b0, 4'd0, 32'd0);
      check("t2 not issued at cdb edge", alu_src1, 32'd5);
      step();
      check("t2 alu_src1", alu_src1, 32'd100);
      check("t2 alu_src2", alu_src2, 32'd3);
      step();
      check("t2 wb_tag", {28'd0, wb_tag}, 32'd2);
      check("t2 wb_value", wb_value, 32'd103);

      // 3: dispatch bypass of same-cycle CDB into src2, sub 0x100 - 0xAA
      disp(4'd5, 6'd34, 32'h100, 4'd0, 1'b0, 32'd0, 4'd4, 1'b1);
      cdb(1'b1, 4'd4, 32'hAA);
      step();
      disp_valid = 1'b0;
      cdb(1'b0, 4'd0, 32'd0);
      step();
      check("t3 alu_src2 bypass", alu_src2, 32'hAA);
      check("t3 alu_src1", alu_src1, 32'h100);
      step();
      check("t3 wb_tag", {28'd0, wb_tag}, 32'd5);
      check("t3 wb_value", wb_value, 32'h56);

      // 4: fill, overflow ignored, wake tags 1 and 3 together
      disp(4'd1, 6'd32, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 1'b0); step();
      disp(4'd2, 6'd32, 32'd0, 4'd8, 1'b1, 32'd2, 4'd0, 1'b0); step();
      disp(4'd3, 6'd32, 32'd0, 4'd7, 1'b1, 32'd3, 4'd0, 1'b0); step();
      check("t4 ready at 3", {31'd0, disp_ready}, 32'd1);
      disp(4'd4, 6'd32, 32'd0, 4'd8, 1'b1, 32'd4, 4'd0, 1'b0); step();
      check("t4 full", {31'd0, disp_ready}, 32'd0);
      disp(4'd6, 6'd32, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0); step();
      disp_valid = 1'b0;
      check("t4 still full", {31'd0, disp_ready}, 32'd0);
      check("t4 no issue", {31'd0, wb_valid}, 32'd0);
      cdb(1'b1, 4'd7, 32'd50);
      step();
      cdb(1'b0, 4'd0, 32'd0);
      check("t4 full at cdb edge", {31'd0, disp_ready}, 32'd0);
      step();
      check("t4 first src1", alu_src1, 32'd50);
      check("t4 first is tag1", alu_src2, 32'd1);
      check("t4 ready again", {31'd0, disp_ready}, 32'd1);
      step();
      check("t4 second is tag3", alu_src2, 32'd3);
      check("t4 wb tag1", {28'd0, wb_tag}, 32'd1);
      check("t4 wb val1", wb_value, 32'd51);
      step();
      check("t4 wb tag3", {28'd0, wb_tag}, 32'd3);
      check("t4 wb val3", wb_value, 32'd53);
      step();
      check("t4 dropped op never issues", {31'd0, wb_valid}, 32'd0);
      do_flush();

      // 5: flush with three waiting, one in issue, plus a same-cycle dispatch
      disp(4'd1, 6'd32, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 1'b0); step();
      disp(4'd2, 6'd32, 32'd0, 4'd12, 1'b1, 32'd2, 4'd0, 1'b0); step();
      disp(4'd3, 6'd32, 32'd0, 4'd12, 1'b1, 32'd3, 4'd0, 1'b0); step();
      disp(4'd4, 6'd32, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0); step();
      disp_valid = 1'b0;
      step();
      check("t5 tag4 in issue", alu_src2, 32'd2);
      disp(4'd5, 6'd32, 32'd9, 4'd0, 1'b0, 32'd9, 4'd0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      disp_valid = 1'b0;
      check("t5 no wb after flush", {31'd0, wb_valid}, 32'd0);
      check("t5 disp_ready", {31'd0, disp_ready}, 32'd1);
      cdb(1'b1, 4'd12, 32'd1);
      step();
      cdb(1'b0, 4'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5 nothing issues", {31'd0, wb_valid}, 32'd0);
      end
      // Occupancy must have restarted at zero: full only after four more
      for (int i = 0; i < 4; i++) begin
         disp(4'(11 + i), 6'd32, 32'd0, 4'd13, 1'b1, 32'd0, 4'd0, 1'b0);
         step();
         check("t5 occupancy probe", {31'd0, disp_ready}, (i == 3) ? 32'd0 : 32'd1);
      end
      disp_valid = 1'b0;
      do_flush();

      // 6: asynchronous reset mid-issue, then normal operation
      disp(4'd9, 6'd32, 32'd20, 4'd0, 1'b0, 32'd22, 4'd0, 1'b0);
      step();
      disp_valid = 1'b0;
      step();
      check("t6 pre-reset alu_src1", alu_src1, 32'd20);
      #2;
      rst = 1'b0;
      #1;
      check("t6 async alu_src1", alu_src1, 32'd0);
      check("t6 async alu_src2", alu_src2, 32'd0);
      check("t6 async alu_funct", {26'd0, alu_funct}, 32'd0);
      check("t6 async wb_valid", {31'd0, wb_valid}, 32'd0);
      check("t6 async wb_tag", {28'd0, wb_tag}, 32'd0);
      check("t6 async wb_value", wb_value, 32'd0);
      check("t6 async disp_ready", {31'd0, disp_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();
      check("t6 no stale wb", {31'd0, wb_valid}, 32'd0);
      disp(4'd10, 6'd32, 32'd4, 4'd0, 1'b0, 32'd6, 4'd0, 1'b0);
      step();
      disp_valid = 1'b0;
      step();
      check("t6 resume alu_src1", alu_src1, 32'd4);
      step();
      check("t6 resume wb_valid", {31'd0, wb_valid}, 32'd1);
      check("t6 resume wb_tag", {28'd0, wb_tag}, 32'd10);
      check("t6 resume wb_value", wb_value, 32'd10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
